// File: rtl/lcd_bus_ctrl.sv
// HD44780 bus sequencer: turns each rising EN request in the core's LCD register into one
// timed setup/enable/hold transaction followed by the controller's command-execution wait.
module lcd_bus_ctrl #(
  parameter int unsigned T_AS_CYC   = 3,
  parameter int unsigned T_PW_CYC   = 25,
  parameter int unsigned T_H_CYC    = 2,
  parameter int unsigned T_EXEC_CYC = 2000,
  parameter int unsigned T_CLR_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_reg,
  input  logic [7:0]  i_lcd_data,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  output logic        o_busy,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_vld,
  output logic        o_ovr
);

  localparam int unsigned MAX_AB  = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > T_H_CYC) ? MAX_AB : T_H_CYC;
  localparam int unsigned MAX_EX  = (T_EXEC_CYC > T_CLR_CYC) ? T_EXEC_CYC : T_CLR_CYC;
  localparam int unsigned MAX_CYC = (MAX_ABC > MAX_EX) ? MAX_ABC : MAX_EX;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] AS_LAST   = CNT_W'(T_AS_CYC - 1);
  localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(T_H_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Only the register bits this block uses are captured.
  logic             on_q;
  logic             en_req_q;
  logic             en_prev_q;
  logic             rs_req_q;
  logic             rw_req_q;
  logic [7:0]       data_req_q;

  logic             lcd_en_q;
  logic             lcd_rs_q;
  logic             lcd_rw_q;
  logic [7:0]       lcd_data_q;
  logic             lcd_oe_q;
  logic             busy_q;
  logic [7:0]       rd_data_q;
  logic             rd_vld_q;
  logic             ovr_q;

  logic             strobe;
  logic             is_clr_home;
  logic [CNT_W-1:0] wait_last;
  logic             unused_reg_bits;

  assign unused_reg_bits = ^i_lcd_reg[30:11];

  assign strobe = en_req_q & ~en_prev_q;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  assign is_clr_home = ~lcd_rs_q & ~lcd_rw_q & (lcd_data_q[7:2] == 6'd0) &
                       (lcd_data_q[1:0] != 2'd0);
  assign wait_last   = is_clr_home ? CLR_LAST : EXEC_LAST;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      on_q       <= 1'b0;
      en_req_q   <= 1'b0;
      en_prev_q  <= 1'b0;
      rs_req_q   <= 1'b0;
      rw_req_q   <= 1'b0;
      data_req_q <= 8'h00;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      lcd_oe_q   <= 1'b1;
      busy_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_vld_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      on_q       <= i_lcd_reg[31];
      en_req_q   <= i_lcd_reg[10];
      rs_req_q   <= i_lcd_reg[9];
      rw_req_q   <= i_lcd_reg[8];
      data_req_q <= i_lcd_reg[7:0];
      en_prev_q  <= en_req_q;
      rd_vld_q   <= 1'b0;

      // Includes the edge where WAIT finishes: busy is still high then, so the request is lost.
      if (strobe && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end

      if ((state_q != S_IDLE) && !on_q) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        lcd_en_q <= 1'b0;
        lcd_oe_q <= 1'b1;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (strobe && on_q) begin
              lcd_rs_q   <= rs_req_q;
              lcd_rw_q   <= rw_req_q;
              lcd_data_q <= data_req_q;
              lcd_oe_q   <= ~rw_req_q;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (cnt_q == AS_LAST) begin
              cnt_q    <= '0;
              lcd_en_q <= 1'b1;
              state_q  <= S_PULSE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_PULSE: begin
            if (cnt_q == PW_LAST) begin
              cnt_q    <= '0;
              lcd_en_q <= 1'b0;
              state_q  <= S_HOLD;
              if (lcd_rw_q) begin
                rd_data_q <= i_lcd_data;
                rd_vld_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_HOLD: begin
            if (cnt_q == H_LAST) begin
              cnt_q    <= '0;
              lcd_oe_q <= 1'b1;
              state_q  <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WAIT: begin
            if (cnt_q == wait_last) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_lcd_on      = on_q;
  assign o_lcd_en      = lcd_en_q;
  assign o_lcd_rs      = lcd_rs_q;
  assign o_lcd_rw      = lcd_rw_q;
  assign o_lcd_data    = lcd_data_q;
  assign o_lcd_data_oe = lcd_oe_q;
  assign o_busy        = busy_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_vld      = rd_vld_q;
  assign o_ovr         = ovr_q;

endmodule
